// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the clock-ratio measurement block.
package clk_div_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StMeasure,
      StDone
   } meter_state_e;

   localparam int unsigned DefWinPeriods = 5;
   localparam int unsigned DefCntW       = 8;
   localparam int unsigned DefTotW       = 16;

endpackage

// File: rtl/clk_period_cnt.sv
// Saturating per-period counter. A clear with enable restarts the count at 1,
// because the clearing strobe edge itself is the first edge of the new period.
module clk_period_cnt
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] cnt_q;

   assign sat   = &cnt_q;
   assign count = cnt_q;

   // Restart, hold at all-ones, or count one edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= enable ? CNT_W'(1) : '0;
      end else if (enable && !sat) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures WIN_PERIODS strobe periods and reports total, min, max and the
// number of long (min+1) periods of a dual-modulus strobe pattern.
module clk_ratio_meter
   import clk_div_pkg::*;
#(
   parameter int unsigned WIN_PERIODS = DefWinPeriods,
   parameter int unsigned CNT_W       = DefCntW,
   parameter int unsigned TOT_W       = DefTotW
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             pulse_in,
   output logic             busy,
   output logic             done,
   output logic [TOT_W-1:0] total_cycles,
   output logic [CNT_W-1:0] period_min,
   output logic [CNT_W-1:0] period_max,
   output logic [TOT_W-1:0] long_cnt,
   output logic             err
);

   localparam int unsigned IDX_W = $clog2(WIN_PERIODS + 1);
   localparam int unsigned SUM_W = TOT_W + 1;

   meter_state_e     state_q;
   logic [IDX_W-1:0] idx_q;
   logic [TOT_W-1:0] acc_total_q;
   logic [CNT_W-1:0] acc_min_q, acc_max_q;
   logic             acc_err_q;
   logic             busy_q, done_q, err_q;
   logic [TOT_W-1:0] total_q, long_q;
   logic [CNT_W-1:0] min_q, max_q;

   logic             cnt_clear, cnt_enable, cnt_sat;
   logic [CNT_W-1:0] period;
   logic [SUM_W-1:0] sum_wide;
   logic             tot_sat, last_period, spread_bad;
   logic [TOT_W-1:0] new_total;
   logic [CNT_W-1:0] new_min, new_max;

   // Counter idles at zero outside ARM/MEASURE so a stale saturation cannot leak.
   assign cnt_clear  = ((state_q != StArm) && (state_q != StMeasure)) || pulse_in;
   assign cnt_enable = (state_q == StMeasure) || ((state_q == StArm) && pulse_in);

   clk_period_cnt #(
      .CNT_W(CNT_W)
   ) u_period_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .clear (cnt_clear),
      .enable(cnt_enable),
      .count (period),
      .sat   (cnt_sat)
   );

   // Running statistics including the period closed by the current strobe.
   always_comb begin
      sum_wide    = SUM_W'(acc_total_q) + SUM_W'(period);
      tot_sat     = sum_wide[TOT_W];
      new_total   = tot_sat ? '1 : sum_wide[TOT_W-1:0];
      new_min     = ((idx_q == '0) || (period < acc_min_q)) ? period : acc_min_q;
      new_max     = ((idx_q == '0) || (period > acc_max_q)) ? period : acc_max_q;
      last_period = (idx_q == IDX_W'(WIN_PERIODS - 1));
      spread_bad  = (new_max - new_min) > CNT_W'(1);
   end

   // long_cnt is formed only while in DONE so it is valid alongside done.
   always_comb begin
      long_cnt = long_q;
      if (state_q == StDone) begin
         long_cnt = total_q - (TOT_W'(WIN_PERIODS) * TOT_W'(min_q));
      end
   end

   // Measurement FSM with registered result outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         acc_total_q <= '0;
         acc_min_q   <= '0;
         acc_max_q   <= '0;
         acc_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         total_q     <= '0;
         min_q       <= '0;
         max_q       <= '0;
         long_q      <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StArm;
                  busy_q  <= 1'b1;
               end
            end
            StArm: begin
               if (pulse_in) begin
                  state_q     <= StMeasure;
                  idx_q       <= '0;
                  acc_total_q <= '0;
                  acc_min_q   <= '0;
                  acc_max_q   <= '0;
                  acc_err_q   <= 1'b0;
               end
            end
            StMeasure: begin
               if (cnt_sat) begin
                  // Strobe lost: report what was accumulated before the stall.
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  total_q <= acc_total_q;
                  min_q   <= acc_min_q;
                  max_q   <= acc_max_q;
                  err_q   <= 1'b1;
               end else if (pulse_in) begin
                  idx_q       <= idx_q + IDX_W'(1);
                  acc_total_q <= new_total;
                  acc_min_q   <= new_min;
                  acc_max_q   <= new_max;
                  acc_err_q   <= acc_err_q | tot_sat;
                  if (last_period) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     total_q <= new_total;
                     min_q   <= new_min;
                     max_q   <= new_max;
                     err_q   <= acc_err_q | tot_sat | spread_bad;
                  end
               end
            end
            StDone: begin
               long_q  <= long_cnt;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign total_cycles = total_q;
   assign period_min   = min_q;
   assign period_max   = max_q;
   assign err          = err_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench: stimulus pushes expected window results, a negedge monitor
// pops and compares them whenever done is presented.
module tb_clk_ratio_meter;

   localparam int unsigned WIN = 5;
   localparam int unsigned CW  = 8;
   localparam int unsigned TW  = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          pulse_in = 1'b0;
   logic          busy, done, err;
   logic [TW-1:0] total_cycles, long_cnt;
   logic [CW-1:0] period_min, period_max;

   typedef struct {
      int total;
      int pmin;
      int pmax;
      int lng;
      int err;
   } res_t;

   res_t exp_q[$];
   res_t last_res;
   int   checks = 0;
   int   errors = 0;

   clk_ratio_meter #(
      .WIN_PERIODS(WIN),
      .CNT_W      (CW),
      .TOT_W      (TW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .pulse_in    (pulse_in),
      .busy        (busy),
      .done        (done),
      .total_cycles(total_cycles),
      .period_min  (period_min),
      .period_max  (period_max),
      .long_cnt    (long_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Reference: window statistics straight from the list of periods.
   function automatic res_t model(input int gaps[$], input bit stalled);
      res_t    r;
      longint  tot = 0;
      int      mn = 0;
      int      mx = 0;
      foreach (gaps[i]) begin
         if (i == 0) begin
            mn = gaps[i];
            mx = gaps[i];
         end
         if (gaps[i] < mn) mn = gaps[i];
         if (gaps[i] > mx) mx = gaps[i];
         tot += gaps[i];
      end
      r.total = (tot > 65535) ? 65535 : int'(tot);
      r.pmin  = mn;
      r.pmax  = mx;
      r.lng   = (r.total - int'(WIN) * mn) & 32'hFFFF;
      r.err   = (stalled || (mx - mn > 1) || (tot > 65535)) ? 1 : 0;
      return r;
   endfunction

   // Monitor: every done must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rstn && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending window");
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("total_cycles", int'(total_cycles), e.total);
            check("period_min", int'(period_min), e.pmin);
            check("period_max", int'(period_max), e.pmax);
            check("long_cnt", int'(long_cnt), e.lng);
            check("err", int'(err), e.err);
            check("busy_at_done", int'(busy), 0);
            last_res = e;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_total"}, int'(total_cycles), 0);
      check({tag, "_min"}, int'(period_min), 0);
      check({tag, "_max"}, int'(period_max), 0);
      check({tag, "_long"}, int'(long_cnt), 0);
      check({tag, "_err"}, int'(err), 0);
   endtask

   task automatic run_window(input int gaps[$], input bit pulse_with_start,
                             input bit mid_start);
      res_t e;
      int   n;
      e        = model(gaps, 1'b0);
      start    = 1'b1;
      pulse_in = pulse_with_start;
      tick();
      start    = 1'b0;
      pulse_in = 1'b0;
      check("busy_in_arm", int'(busy), 1);
      repeat ($urandom_range(0, 3)) tick();
      check("hold_total", int'(total_cycles), last_res.total);
      exp_q.push_back(e);
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      foreach (gaps[i]) begin
         repeat (gaps[i] - 1) tick();
         pulse_in = 1'b1;
         if (mid_start && i == 2) start = 1'b1;
         tick();
         pulse_in = 1'b0;
         start    = 1'b0;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("done_pending", exp_q.size(), 0);
      tick();
      tick();
   endtask

   initial begin
      int g[$];
      int n;
      last_res = '{0, 0, 0, 0, 0};

      repeat (2) tick();
      check_zero("reset");
      rstn = 1'b1;
      tick();

      g = '{9, 8, 9, 8, 9};
      run_window(g, 1'b0, 1'b0);
      g = '{4, 4, 4, 4, 4};
      run_window(g, 1'b0, 1'b0);
      g = '{8, 10, 8, 10, 8};
      run_window(g, 1'b0, 1'b0);

      // Lost strobe: one strobe then silence until the period counter saturates.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      g = {};
      exp_q.push_back(model(g, 1'b1));
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      check("sat_latency", n, 255);
      tick();
      check("sat_busy_after", int'(busy), 0);
      check("sat_done_after", int'(done), 0);
      tick();

      // Reset after the third strobe discards the window.
      start = 1'b1;
      tick();
      start    = 1'b0;
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      repeat (8) tick();
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      repeat (7) tick();
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      rstn     = 1'b0;
      tick();
      check_zero("midreset");
      rstn     = 1'b1;
      last_res = '{0, 0, 0, 0, 0};
      repeat (20) tick();
      g = '{9, 8, 9, 8, 9};
      run_window(g, 1'b0, 1'b0);

      // Ignored start requests: with the first strobe in IDLE and during MEASURE.
      run_window(g, 1'b1, 1'b1);

      // Random dual-modulus and occasionally malformed windows.
      for (int w = 0; w < 20; w++) begin
         int base;
         int spread;
         base   = $urandom_range(1, 30);
         spread = ($urandom_range(0, 3) == 0) ? 3 : 1;
         g = {};
         for (int i = 0; i < int'(WIN); i++) g.push_back(base + $urandom_range(0, spread));
         run_window(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
